geofence_poly: RTL and testbench



---
 rtl/geofence_pkg.sv | 16 +
 rtl/geofence_poly_if.sv | 11 +
 rtl/geofence_cross.sv | 25 ++
 rtl/geofence_poly.sv | 118 +++++++++++
 tb/tb_geofence_poly.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/geofence_pkg.sv
// geofence_pkg: shared FSM state type, arithmetic width helpers and sort-length helper.
package geofence_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, SORT, DET, DONE} state_e;
  function automatic int diff_w(input int cw);
    return cw + 1;
  endfunction
  function automatic int prod_w(input int cw);
    return 2 * cw + 2;
  endfunction
  function automatic int cross_w(input int cw);
    return 2 * cw + 3;
  endfunction
  function automatic int sort_cycles(input int nv);
    return (nv - 1) * (nv - 2) / 2;
  endfunction
endpackage

// File: rtl/geofence_poly_if.sv
// geofence_poly_if: coordinate input stream plus one-cycle result strobe.
interface geofence_poly_if #(parameter int CW = 10);
  logic          in_valid;
  logic [CW-1:0] X;
  logic [CW-1:0] Y;
  logic          in_ready;
  logic          valid;
  logic          is_inside;
  modport master (output in_valid, X, Y, input in_ready, valid, is_inside);
  modport slave  (input in_valid, X, Y, output in_ready, valid, is_inside);
endinterface

// File: rtl/geofence_cross.sv
// geofence_cross: signed cross product (a-o) x (b-o) at full width, no truncation.
module geofence_cross import geofence_pkg::*; #(
  parameter int CW = 10
) (
  input  logic [CW-1:0]                   ox,
  input  logic [CW-1:0]                   oy,
  input  logic [CW-1:0]                   ax,
  input  logic [CW-1:0]                   ay,
  input  logic [CW-1:0]                   bx,
  input  logic [CW-1:0]                   by,
  output logic signed [cross_w(CW)-1:0]   c
);
  localparam int DW = diff_w(CW);
  localparam int PW = prod_w(CW);
  localparam int XW = cross_w(CW);
  logic signed [DW-1:0] dxa, dya, dxb, dyb;
  logic signed [PW-1:0] p1, p2;
  assign dxa = $signed({1'b0, ax}) - $signed({1'b0, ox});
  assign dya = $signed({1'b0, ay}) - $signed({1'b0, oy});
  assign dxb = $signed({1'b0, bx}) - $signed({1'b0, ox});
  assign dyb = $signed({1'b0, by}) - $signed({1'b0, oy});
  assign p1 = PW'(dxa) * PW'(dyb);
  assign p2 = PW'(dxb) * PW'(dya);
  assign c = XW'(p1) - XW'(p2);
endmodule

// File: rtl/geofence_poly.sv
// geofence_poly: strict point-in-convex-polygon test; vertices sorted CCW about v[0], then edge-sign test.
// Define GEOFENCE_EARLY_EXIT_EN to leave the edge test on the first non-positive edge.
module geofence_poly import geofence_pkg::*; #(
  parameter int CW = 10,
  parameter int NV = 6
) (
  input logic             clk,
  input logic             reset,
  geofence_poly_if.slave  bus
);
  localparam int IW = $clog2(NV);
  localparam int XW = cross_w(CW);
  state_e state_q, state_d;
  logic [IW-1:0] i_q, i_d, j_q, j_d, k_q, k_d, kn;
  logic [CW-1:0] px_q, px_d, py_q, py_d;
  logic [CW-1:0] vx_q [NV];
  logic [CW-1:0] vy_q [NV];
  logic [CW-1:0] vx_d [NV];
  logic [CW-1:0] vy_d [NV];
  logic all_pos_q, all_pos_d, take, sorting;
  logic [CW-1:0] ox, oy, ax, ay, bx, by;
  logic signed [XW-1:0] c;
  assign sorting = state_q == SORT;
  assign kn = (k_q == IW'(NV - 1)) ? '0 : k_q + 1'b1;
  assign take = bus.in_valid && bus.in_ready;
  assign bus.in_ready = state_q == IDLE || state_q == LOAD;
  assign bus.valid = state_q == DONE;
  assign bus.is_inside = bus.valid && all_pos_q;
  // One shared cross unit: angular compare about v[0] in SORT, edge-vs-point in DET.
  assign ox = sorting ? vx_q[0] : vx_q[k_q];
  assign oy = sorting ? vy_q[0] : vy_q[k_q];
  assign ax = sorting ? vx_q[i_q] : vx_q[kn];
  assign ay = sorting ? vy_q[i_q] : vy_q[kn];
  assign bx = sorting ? vx_q[j_q] : px_q;
  assign by = sorting ? vy_q[j_q] : py_q;
  geofence_cross #(.CW(CW)) u_cross (.ox(ox), .oy(oy), .ax(ax), .ay(ay), .bx(bx), .by(by), .c(c));
  always_comb begin
    state_d = state_q;
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    px_d = px_q;
    py_d = py_q;
    vx_d = vx_q;
    vy_d = vy_q;
    all_pos_d = all_pos_q;
    case (state_q)
      IDLE: if (take) begin
        px_d = bus.X;
        py_d = bus.Y;
        k_d = '0;
        state_d = LOAD;
      end
      LOAD: if (take) begin
        vx_d[k_q] = bus.X;
        vy_d[k_q] = bus.Y;
        k_d = kn;
        if (k_q == IW'(NV - 1)) begin
          i_d = IW'(1);
          j_d = IW'(2);
          state_d = SORT;
        end
      end
      SORT: begin
        if (c < 0) begin
          vx_d[i_q] = vx_q[j_q];
          vy_d[i_q] = vy_q[j_q];
          vx_d[j_q] = vx_q[i_q];
          vy_d[j_q] = vy_q[i_q];
        end
        if (j_q != IW'(NV - 1)) j_d = j_q + 1'b1;
        else if (i_q != IW'(NV - 2)) begin
          i_d = i_q + 1'b1;
          j_d = i_q + IW'(2);
        end else begin
          k_d = '0;
          all_pos_d = 1'b1;
          state_d = DET;
        end
      end
      DET: begin
        all_pos_d = all_pos_q && (c > 0);
        k_d = kn;
`ifdef GEOFENCE_EARLY_EXIT_EN
        state_d = (k_q == IW'(NV - 1) || c <= 0) ? DONE : DET;
`else
        state_d = (k_q == IW'(NV - 1)) ? DONE : DET;
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
      px_q <= '0;
      py_q <= '0;
      all_pos_q <= 1'b0;
      for (int n = 0; n < NV; n++) begin
        vx_q[n] <= '0;
        vy_q[n] <= '0;
      end
    end else begin
      state_q <= state_d;
      i_q <= i_d;
      j_q <= j_d;
      k_q <= k_d;
      px_q <= px_d;
      py_q <= py_d;
      all_pos_q <= all_pos_d;
      vx_q <= vx_d;
      vy_q <= vy_d;
    end
  end
endmodule

// File: tb/tb_geofence_poly.sv
// tb_geofence_poly: directed scoreboard bench for a hexagon (NV=6, CW=10) and a triangle (NV=3, CW=12).
module tb_geofence_poly;
  typedef struct {
    logic ins;
    int   cyc;
    bit   early;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t q6[$];
  exp_t q3[$];
  exp_t e6, e3;
  int hx[6] = '{0, 8, 4, 12, 4, 8};
  int hy[6] = '{4, 8, 0, 4, 8, 0};
  geofence_poly_if #(.CW(10)) if6();
  geofence_poly_if #(.CW(12)) if3();
  geofence_poly #(.CW(10), .NV(6)) u6 (.clk(clk), .reset(reset), .bus(if6.slave));
  geofence_poly #(.CW(12), .NV(3)) u3 (.clk(clk), .reset(reset), .bus(if3.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (!reset && if6.valid) begin
    if (q6.size() == 0) chk("unexpected_valid6", 1, 0);
    else begin
      e6 = q6.pop_front();
      chk("inside6", int'(if6.is_inside), int'(e6.ins));
      if (e6.early) chk("early6", int'(cyc < e6.cyc), 1);
      else chk("latency6", cyc, e6.cyc);
    end
  end

  always @(negedge clk) if (!reset && if3.valid) begin
    if (q3.size() == 0) chk("unexpected_valid3", 1, 0);
    else begin
      e3 = q3.pop_front();
      chk("inside3", int'(if3.is_inside), int'(e3.ins));
      chk("latency3", cyc, e3.cyc);
    end
  end

  task automatic beat6(input int x, input int y, output int t);
    int n = 0;
    @(negedge clk);
    if6.in_valid = 1'b1;
    if6.X = 10'(x);
    if6.Y = 10'(y);
    while (!if6.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("beat6_timeout", n, 0);
    t = cyc;
  endtask

  task automatic beat3(input int x, input int y, output int t);
    int n = 0;
    @(negedge clk);
    if3.in_valid = 1'b1;
    if3.X = 12'(x);
    if3.Y = 12'(y);
    while (!if3.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("beat3_timeout", n, 0);
    t = cyc;
  endtask

  task automatic gap6();
    @(negedge clk);
    if6.in_valid = 1'b0;
    if6.X = 10'h3ff;
    if6.Y = 10'h3ff;
  endtask

  task automatic hex(input int px, input int py, input logic ins, input bit gaps, input bit early);
    int t;
    beat6(px, py, t);
    for (int i = 0; i < 6; i++) begin
      if (gaps) gap6();
      beat6(hx[i], hy[i], t);
    end
    q6.push_back('{ins, t + 17, early});
    gap6();
  endtask

  task automatic drain();
    int n = 0;
    while ((q6.size() != 0 || q3.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("drain_timeout", q6.size() + q3.size(), 0);
  endtask

  initial begin
    int t, t0, t2;
    bit ee;
    if6.in_valid = 1'b0;
    if6.X = '0;
    if6.Y = '0;
    if3.in_valid = 1'b0;
    if3.X = '0;
    if3.Y = '0;
`ifdef GEOFENCE_EARLY_EXIT_EN
    ee = 1'b1;
`else
    ee = 1'b0;
`endif
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_ready6", int'(if6.in_ready), 1);
    chk("rst_valid6", int'(if6.valid), 0);
    chk("rst_inside6", int'(if6.is_inside), 0);
    chk("rst_ready3", int'(if3.in_ready), 1);
    chk("rst_valid3", int'(if3.valid), 0);
    chk("rst_inside3", int'(if3.is_inside), 0);
    hex(6, 4, 1'b1, 1'b0, 1'b0);
    hex(13, 4, 1'b0, 1'b0, ee);
    hex(6, 0, 1'b0, 1'b0, 1'b0);
    hex(4, 0, 1'b0, 1'b0, 1'b0);
    hex(2, 4, 1'b1, 1'b0, 1'b0);
    hex(6, 4, 1'b1, 1'b1, 1'b0);
    drain();
    beat6(6, 4, t);
    for (int i = 0; i < 6; i++) beat6(hx[i], hy[i], t);
    gap6();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midsort_valid", int'(if6.valid), 0);
    chk("midsort_ready", int'(if6.in_ready), 1);
    hex(6, 4, 1'b1, 1'b0, 1'b0);
    beat3(1000, 1000, t);
    beat3(0, 0, t);
    beat3(4000, 0, t);
    beat3(0, 4000, t);
    q3.push_back('{1'b1, t + 5, 1'b0});
    t0 = t;
    beat3(3000, 3000, t2);
    chk("b2b_accept", t2, t0 + 6);
    beat3(0, 0, t);
    beat3(4000, 0, t);
    beat3(0, 4000, t);
    q3.push_back('{1'b0, t + 5, 1'b0});
    @(negedge clk);
    if3.in_valid = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
